// File: rtl/npc_pkg.sv
// Shared definitions for the NPC PC sequencer: PC-source encodings, FSM states, reset PC.
// Optional feature macro used by the sequencer: NPC_PC_MISALIGN_TRAP_EN.
package npc_pkg;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_SRC_IMM    = 2'b01;
  localparam logic [1:0] PC_SRC_ALU    = 2'b10;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b11;

  typedef enum logic [2:0] {
    SEQ_IDLE = 3'd0,
    SEQ_REQ  = 3'd1,
    SEQ_WAIT = 3'd2,
    SEQ_EXEC = 3'd3,
    SEQ_CMT  = 3'd4,
    SEQ_HALT = 3'd5
  } seq_state_e;

  function automatic logic pc_misaligned(input logic [1:0] pc_low);
    return pc_low != 2'b00;
  endfunction

endpackage

// File: rtl/npc_pc_sequencer_if.sv
// Instruction-fetch port between the PC sequencer (master) and instruction memory (slave).
// The request address is the sequencer's pc_o output.
interface npc_pc_sequencer_if;

  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_inst;

  modport master (
    output ifu_req_valid,
    input  ifu_req_ready,
    input  ifu_rsp_valid,
    input  ifu_rsp_inst
  );

  modport slave (
    input  ifu_req_valid,
    output ifu_req_ready,
    output ifu_rsp_valid,
    output ifu_rsp_inst
  );

endinterface

// File: rtl/npc_next_pc.sv
// Combinational next-PC select: PC+4, PC+imm, jalr target (bit 0 cleared) or conditional branch.
// All arithmetic wraps modulo 2^XLEN.
module npc_next_pc
  import npc_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  input  logic            br_taken,
  output logic [XLEN-1:0] next_pc
);

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_plus_imm;
  logic [XLEN-1:0] jalr_target;

  always_comb begin
    pc_plus4    = pc + XLEN'(4);
    pc_plus_imm = pc + imm;
    jalr_target = {alu_result[XLEN-1:1], 1'b0};
  end

  always_comb begin
    next_pc = pc_plus4;
    case (pc_src)
      PC_SRC_PLUS4:  next_pc = pc_plus4;
      PC_SRC_IMM:    next_pc = pc_plus_imm;
      PC_SRC_ALU:    next_pc = jalr_target;
      PC_SRC_BRANCH: next_pc = br_taken ? pc_plus_imm : pc_plus4;
      default:       next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/npc_pc_sequencer.sv
// Architectural PC owner and single-instruction-in-flight fetch/execute/commit sequencer.
// Optional misaligned-target trap enabled by defining NPC_PC_MISALIGN_TRAP_EN.
module npc_pc_sequencer
  import npc_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic                       clk,
  input  logic                       rst,
  npc_pc_sequencer_if.master         ifu,
  output logic [31:0]                inst_o,
  output logic                       inst_valid,
  output logic [XLEN-1:0]            pc_o,
  input  logic [1:0]                 pc_src,
  input  logic [XLEN-1:0]            imm,
  input  logic [XLEN-1:0]            alu_result,
  input  logic                       br_taken,
  input  logic                       exu_done,
  input  logic                       halt,
  output logic                       commit,
`ifdef NPC_PC_MISALIGN_TRAP_EN
  output logic                       misalign,
`endif
  output logic                       halted
);

  seq_state_e      state_q;
  seq_state_e      state_d;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] next_pc_q;
  logic [XLEN-1:0] next_pc;
  logic [31:0]     inst_q;
  logic            inst_valid_q;

  logic            rsp_accept;
  logic            exec_retire;
  logic            exec_fault;

  npc_next_pc #(
    .XLEN (XLEN)
  ) u_next_pc (
    .pc         (pc_q),
    .pc_src     (pc_src),
    .imm        (imm),
    .alu_result (alu_result),
    .br_taken   (br_taken),
    .next_pc    (next_pc)
  );

  // A fault diverts a completing instruction to HALT before its PC is ever latched.
`ifdef NPC_PC_MISALIGN_TRAP_EN
  logic misalign_q;
  logic target_misaligned;
  always_comb target_misaligned = pc_misaligned(next_pc[1:0]);
`else
  logic target_misaligned;
  always_comb target_misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    ifu.ifu_req_valid = 1'b0;
    commit            = 1'b0;
    rsp_accept        = 1'b0;
    exec_retire       = 1'b0;
    exec_fault        = 1'b0;
    case (state_q)
      SEQ_IDLE: state_d = SEQ_REQ;
      SEQ_REQ: begin
        ifu.ifu_req_valid = 1'b1;
        if (ifu.ifu_req_ready) state_d = SEQ_WAIT;
      end
      SEQ_WAIT: begin
        if (ifu.ifu_rsp_valid) begin
          rsp_accept = 1'b1;
          state_d    = SEQ_EXEC;
        end
      end
      SEQ_EXEC: begin
        if (exu_done) begin
          if (halt) begin
            state_d = SEQ_HALT;
          end else if (target_misaligned) begin
            exec_fault = 1'b1;
            state_d    = SEQ_HALT;
          end else begin
            exec_retire = 1'b1;
            state_d     = SEQ_CMT;
          end
        end
      end
      SEQ_CMT: begin
        commit  = 1'b1;
        state_d = SEQ_REQ;
      end
      SEQ_HALT: state_d = SEQ_HALT;
      default:  state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      next_pc_q    <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      inst_valid_q <= rsp_accept;
      if (rsp_accept)         inst_q    <= ifu.ifu_rsp_inst;
      if (exec_retire)        next_pc_q <= next_pc;
      if (state_q == SEQ_CMT) pc_q      <= next_pc_q;
    end
  end

`ifdef NPC_PC_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (exec_fault) begin
      misalign_q <= 1'b1;
    end
  end
  assign misalign = misalign_q;
`endif

  assign pc_o       = pc_q;
  assign inst_o     = inst_q;
  assign inst_valid = inst_valid_q;
  assign halted     = (state_q == SEQ_HALT);

endmodule
